// File: rtl/mem_access_unit.sv
// Memory stage: word access to on-chip RAM with programmable wait states.
// Ports: MemRead/MemWrite/addr/wdata in; rdata, ready, busy, err out.
module mem_access_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_AW  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdata_q;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic commit;

  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the RAM.
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:MEM_AW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead && MemWrite) begin
          err_d = 1'b1;
        end else if (MemRead || MemWrite) begin
          we_d    = MemWrite;
          idx_d   = addr[MEM_AW-1:0];
          wdat_d  = wdata;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (commit && !we_q) begin
      rdata_q <= mem[idx_q];
    end
  end

  // RAM is not reset; commit is gated by state so reset cancels a pending write.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed steps, scoreboard queue of expected results.
// Drives on negedge, samples on negedge.
module tb_mem_access_unit;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int MAW = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .MEM_AW (MAW),
    .LATENCY(LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .busy    (busy),
    .err     (err)
  );

  typedef struct {
    bit             rd;
    logic [MAW-1:0] idx;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ram_m [2**MAW];
  logic [DW-1:0] last_rd = '0;
  int checks = 0;
  int errors = 0;
  int p1 = 0;
  int p2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    exp_t e;
    e.rd   = !wr;
    e.idx  = a[MAW-1:0];
    e.data = wr ? d : ram_m[a[MAW-1:0]];
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.rd) begin
        chk({tag, "_rdata"}, 32'(rdata), 32'(e.data));
        last_rd = e.data;
      end else begin
        ram_m[e.idx] = e.data;
      end
    end
  endtask

  task automatic run_access(input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input string tag);
    int nb;
    int lat;
    nb  = 0;
    lat = 0;
    @(negedge clk);
    MemRead  = !wr;
    MemWrite = wr;
    addr     = a;
    wdata    = d;
    push(wr, a, d);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ready) begin
        lat      = k;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        pop_chk(tag);
      end
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    // Ready is seen LAT cycles after the accepting edge.
    chk({tag, "_lat"}, 32'(lat), 32'(LAT + 1));
    @(negedge clk);
    chk({tag, "_ready1"}, 32'(ready), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_busy"}, 32'(nb), 32'(LAT + 1));
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: write then read back
    run_access(1'b1, 16'h0010, 16'hBEEF, "t1_wr");
    chk("t1_rdata_hold", 32'(rdata), 0);
    run_access(1'b0, 16'h0010, 16'h0000, "t1_rd");

    // 2: both requests high
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    addr     = 16'h0010;
    wdata    = 16'hDEAD;
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    chk("t2_err", 32'(err), 1);
    chk("t2_ready", 32'(ready), 0);
    chk("t2_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t2_err_pulse", 32'(err), 0);
    chk("t2_ready2", 32'(ready), 0);
    chk("t2_rdata", 32'(rdata), 32'(last_rd));
    run_access(1'b0, 16'h0010, 16'h0000, "t2_rd");

    // 3: address aliasing
    run_access(1'b1, 16'h0105, 16'h1234, "t3_wr");
    run_access(1'b0, 16'h0005, 16'h0000, "t3_rd");

    // 4: operands change during ACCESS
    run_access(1'b1, 16'h0020, 16'h2222, "t4_pre");
    @(negedge clk);
    MemWrite = 1'b1;
    addr     = 16'h0040;
    wdata    = 16'h7777;
    push(1'b1, 16'h0040, 16'h7777);
    @(negedge clk);
    MemWrite = 1'b0;
    addr     = 16'h0020;
    wdata    = 16'h0000;
    p1 = 0;
    p2 = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (ready) begin
        if (p1 == 0) begin
          p1 = k;
          pop_chk("t4_wr");
        end else begin
          p2 = k;
        end
      end
    end
    chk("t4_lat", 32'(p1), 32'(LAT + 1));
    chk("t4_once", 32'(p2), 0);
    run_access(1'b0, 16'h0040, 16'h0000, "t4_rd40");
    run_access(1'b0, 16'h0020, 16'h0000, "t4_rd20");

    // 5: reset mid-write at cnt=1
    run_access(1'b1, 16'h0030, 16'hAAAA, "t5_pre");
    @(negedge clk);
    MemWrite = 1'b1;
    addr     = 16'h0030;
    wdata    = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(ready), 0);
    chk("t5_err", 32'(err), 0);
    chk("t5_rdata", 32'(rdata), 0);
    MemWrite = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    last_rd = '0;
    run_access(1'b0, 16'h0030, 16'h0000, "t5_rd");

    // 6: request held through DONE
    @(negedge clk);
    MemRead = 1'b1;
    addr    = 16'h0005;
    push(1'b0, 16'h0005, 16'h0000);
    push(1'b0, 16'h0005, 16'h0000);
    p1 = 0;
    p2 = 0;
    for (int k = 1; k <= 40 && p2 == 0; k++) begin
      @(negedge clk);
      if (ready) begin
        pop_chk("t6");
        if (p1 == 0) begin
          p1 = k;
        end else begin
          p2 = k;
          MemRead = 1'b0;
        end
      end
    end
    MemRead = 1'b0;
    chk("t6_first", 32'(p1), 32'(LAT + 1));
    // DONE, one IDLE accept cycle, then LAT wait cycles: LAT+1 quiet cycles.
    chk("t6_gap", 32'(p2 - p1), 32'(LAT + 2));
    @(negedge clk);
    chk("t6_ready_end", 32'(ready), 0);
    chk("t6_idle_end", 32'(busy), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
